// File: rtl/lc2k_control_fsm_if.sv
`default_nettype none
// ============================================================================
// Module      : lc2k_control_fsm_if
// Description : Control/handshake bundle between the LC2K multicycle control
//               sequencer and the datapath/memory port.
//               master : the sequencer (drives state, selects, enables,
//                        mem_req/mem_write, halted, error, instr_count)
//               slave  : the datapath side (drives opcode, mem_ready,
//                        branch_eq)
// Revision    : 1.0 - initial release
// ============================================================================
interface lc2k_control_fsm_if #(
    parameter int COUNT_WIDTH = 32
);
    logic [2:0]             opcode;
    logic                   mem_ready;
    logic                   branch_eq;
    logic [2:0]             state;
    logic                   mem_req;
    logic                   mem_write;
    logic                   ir_write;
    logic                   reg_write;
    logic                   write_reg_sel;
    logic [1:0]             write_data_sel;
    logic                   alu_srcb;
    logic [1:0]             alu_op;
    logic                   pc_write;
    logic [1:0]             pc_src;
    logic                   halted;
    logic                   error;
    logic [COUNT_WIDTH-1:0] instr_count;

    modport master (
        input  opcode, mem_ready, branch_eq,
        output state, mem_req, mem_write, ir_write, reg_write, write_reg_sel,
               write_data_sel, alu_srcb, alu_op, pc_write, pc_src, halted,
               error, instr_count
    );

    modport slave (
        output opcode, mem_ready, branch_eq,
        input  state, mem_req, mem_write, ir_write, reg_write, write_reg_sel,
               write_data_sel, alu_srcb, alu_op, pc_write, pc_src, halted,
               error, instr_count
    );
endinterface
`default_nettype wire

// File: rtl/lc2k_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : lc2k_control_fsm
// Description : Multicycle control sequencer for the LC2K datapath. Steps each
//               instruction through FETCH/DECODE/EXEC/MEM/WB, drives datapath
//               selects/enables per state, handshakes with variable-latency
//               memory, counts retired instructions, optional mem timeout.
// Ports       : clk   - clock, rising edge
//               rst_n - asynchronous active-low reset
//               bus   - lc2k_control_fsm_if.master (opcode, mem_ready,
//                       branch_eq in; state, control outputs, halted, error,
//                       instr_count out)
// Revision    : 1.0 - initial release
// ============================================================================
module lc2k_control_fsm #(
    parameter int          COUNT_WIDTH    = 32,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    lc2k_control_fsm_if.master        bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALTED = 3'd5
    } state_t;

    localparam logic [2:0] c_OP_ADD  = 3'd0;
    localparam logic [2:0] c_OP_NOR  = 3'd1;
    localparam logic [2:0] c_OP_LW   = 3'd2;
    localparam logic [2:0] c_OP_SW   = 3'd3;
    localparam logic [2:0] c_OP_BEQ  = 3'd4;
    localparam logic [2:0] c_OP_JALR = 3'd5;
    localparam logic [2:0] c_OP_HALT = 3'd6;

    localparam logic                   c_TIMEOUT_EN   = (TIMEOUT_CYCLES > 0);
    localparam logic [31:0]            c_TIMEOUT_LAST =
        (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;
    localparam logic [COUNT_WIDTH-1:0] c_COUNT_ONE    = COUNT_WIDTH'(1);

    state_t                 r_state;
    state_t                 w_next;
    logic [2:0]             r_opcode;
    logic [COUNT_WIDTH-1:0] r_count;
    logic                   r_error;
    logic [31:0]            r_wait;

    logic       w_retire;
    logic       w_timeout;
    logic       w_tmo_hit;
    logic       w_mem_req;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_write;
    logic       w_write_reg_sel;
    logic [1:0] w_write_data_sel;
    logic       w_alu_srcb;
    logic [1:0] w_alu_op;
    logic       w_pc_write;
    logic [1:0] w_pc_src;
    logic       w_halted;

    // This cycle would be the TIMEOUT_CYCLES-th consecutive unanswered cycle.
    assign w_tmo_hit = c_TIMEOUT_EN && (r_wait == c_TIMEOUT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_FETCH;
            r_opcode <= 3'd7;
            r_count  <= '0;
            r_error  <= 1'b0;
            r_wait   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_opcode <= bus.opcode;
            end
            if (w_retire) begin
                r_count <= r_count + c_COUNT_ONE;
            end
            if (w_timeout) begin
                r_error <= 1'b1;
            end
            // Clearing on any state change covers entry to FETCH and MEM.
            if ((w_next != r_state) || bus.mem_ready) begin
                r_wait <= '0;
            end else if (w_mem_req) begin
                r_wait <= r_wait + 32'd1;
            end
        end
    end

    always_comb begin
        w_next           = r_state;
        w_retire         = 1'b0;
        w_timeout        = 1'b0;
        w_mem_req        = 1'b0;
        w_mem_write      = 1'b0;
        w_ir_write       = 1'b0;
        w_reg_write      = 1'b0;
        w_write_reg_sel  = 1'b0;
        w_write_data_sel = 2'd0;
        w_alu_srcb       = 1'b0;
        w_alu_op         = 2'd0;
        w_pc_write       = 1'b0;
        w_pc_src         = 2'd0;
        w_halted         = 1'b0;
        // Outputs are forced quiet while reset is asserted so mem_req drops
        // the instant rst_n falls, not at the next edge.
        if (rst_n) begin
            case (r_state)
                S_FETCH: begin
                    w_mem_req = 1'b1;
                    if (bus.mem_ready) begin
                        w_ir_write = 1'b1;
                        w_next     = S_DECODE;
                    end else if (w_tmo_hit) begin
                        w_timeout = 1'b1;
                        w_next    = S_HALTED;
                    end
                end
                S_DECODE: begin
                    w_next = S_EXEC;
                end
                S_EXEC: begin
                    case (r_opcode)
                        c_OP_ADD, c_OP_NOR: begin
                            w_alu_srcb = 1'b1;
                            w_alu_op   = (r_opcode == c_OP_NOR) ? 2'd1 : 2'd0;
                            w_next     = S_WB;
                        end
                        c_OP_LW, c_OP_SW: begin
                            w_next = S_MEM;
                        end
                        c_OP_BEQ: begin
                            w_alu_srcb = 1'b1;
                            w_alu_op   = 2'd2;
                            w_pc_write = 1'b1;
                            w_pc_src   = bus.branch_eq ? 2'd1 : 2'd0;
                            w_retire   = 1'b1;
                            w_next     = S_FETCH;
                        end
                        c_OP_JALR: begin
                            w_reg_write      = 1'b1;
                            w_write_data_sel = 2'd2;
                            w_pc_write       = 1'b1;
                            w_pc_src         = 2'd2;
                            w_retire         = 1'b1;
                            w_next           = S_FETCH;
                        end
                        c_OP_HALT: begin
                            w_pc_write = 1'b1;
                            w_retire   = 1'b1;
                            w_next     = S_HALTED;
                        end
                        default: begin
                            w_pc_write = 1'b1;
                            w_retire   = 1'b1;
                            w_next     = S_FETCH;
                        end
                    endcase
                end
                S_MEM: begin
                    w_mem_req   = 1'b1;
                    w_mem_write = (r_opcode == c_OP_SW);
                    if (bus.mem_ready) begin
                        if (r_opcode == c_OP_SW) begin
                            w_pc_write = 1'b1;
                            w_retire   = 1'b1;
                            w_next     = S_FETCH;
                        end else begin
                            w_next = S_WB;
                        end
                    end else if (w_tmo_hit) begin
                        w_timeout = 1'b1;
                        w_next    = S_HALTED;
                    end
                end
                S_WB: begin
                    w_reg_write = 1'b1;
                    w_pc_write  = 1'b1;
                    w_retire    = 1'b1;
                    w_next      = S_FETCH;
                    // Only add/nor/lw reach WB; lw uses the zero defaults.
                    if (r_opcode != c_OP_LW) begin
                        w_write_reg_sel  = 1'b1;
                        w_write_data_sel = 2'd1;
                        w_alu_srcb       = 1'b1;
                        w_alu_op         = (r_opcode == c_OP_NOR) ? 2'd1 : 2'd0;
                    end
                end
                S_HALTED: begin
                    w_halted = 1'b1;
                end
                default: begin
                    w_next = S_FETCH;
                end
            endcase
        end
    end

    assign bus.state          = r_state;
    assign bus.mem_req        = w_mem_req;
    assign bus.mem_write      = w_mem_write;
    assign bus.ir_write       = w_ir_write;
    assign bus.reg_write      = w_reg_write;
    assign bus.write_reg_sel  = w_write_reg_sel;
    assign bus.write_data_sel = w_write_data_sel;
    assign bus.alu_srcb       = w_alu_srcb;
    assign bus.alu_op         = w_alu_op;
    assign bus.pc_write       = w_pc_write;
    assign bus.pc_src         = w_pc_src;
    assign bus.halted         = w_halted;
    assign bus.error          = r_error;
    assign bus.instr_count    = r_count;
endmodule
`default_nettype wire

// File: tb/tb_lc2k_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_lc2k_control_fsm
// Description : Self-checking bench for lc2k_control_fsm. Each instruction is
//               expanded into its sequence of phases (fetch waits, decode,
//               exec, memory waits, writeback); a table of per-phase control
//               values gives the expected outputs, checked every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lc2k_control_fsm;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lc2k_control_fsm_if #(.COUNT_WIDTH(32)) bus();

    lc2k_control_fsm #(.COUNT_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    typedef struct packed {
        logic [2:0] st;
        logic       mem_req;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       wrs;
        logic [1:0] wds;
        logic       alu_srcb;
        logic [1:0] alu_op;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       halted;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;
    exp_t exp_o;
    int   exp_count = 0;
    bit   exp_error = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    // Expected controls for one cycle, from the phase the instruction is in.
    function automatic exp_t model(input int ph, input int op, input bit mr, input bit beq);
        exp_t e = '0;
        e.st = 3'(ph);
        case (ph)
            0: begin e.mem_req = 1'b1; e.ir_write = mr; end
            2: case (op)
                0, 1: begin e.alu_srcb = 1'b1; e.alu_op = 2'(op); end
                4: begin
                    e.alu_srcb = 1'b1; e.alu_op = 2'd2;
                    e.pc_write = 1'b1; e.pc_src = beq ? 2'd1 : 2'd0;
                end
                5: begin
                    e.reg_write = 1'b1; e.wds = 2'd2;
                    e.pc_write = 1'b1; e.pc_src = 2'd2;
                end
                6, 7: e.pc_write = 1'b1;
                default: ;
            endcase
            3: begin
                e.mem_req = 1'b1; e.mem_write = (op == 3);
                e.pc_write = (op == 3) && mr;
            end
            4: begin
                e.reg_write = 1'b1; e.pc_write = 1'b1;
                if (op < 2) begin
                    e.wrs = 1'b1; e.wds = 2'd1; e.alu_srcb = 1'b1; e.alu_op = 2'(op);
                end
            end
            5: e.halted = 1'b1;
            default: ;
        endcase
        return e;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("state",          32'(bus.state),          32'(exp_o.st));
            chk("mem_req",        32'(bus.mem_req),        32'(exp_o.mem_req));
            chk("mem_write",      32'(bus.mem_write),      32'(exp_o.mem_write));
            chk("ir_write",       32'(bus.ir_write),       32'(exp_o.ir_write));
            chk("reg_write",      32'(bus.reg_write),      32'(exp_o.reg_write));
            chk("write_reg_sel",  32'(bus.write_reg_sel),  32'(exp_o.wrs));
            chk("write_data_sel", 32'(bus.write_data_sel), 32'(exp_o.wds));
            chk("alu_srcb",       32'(bus.alu_srcb),       32'(exp_o.alu_srcb));
            chk("alu_op",         32'(bus.alu_op),         32'(exp_o.alu_op));
            chk("pc_write",       32'(bus.pc_write),       32'(exp_o.pc_write));
            chk("pc_src",         32'(bus.pc_src),         32'(exp_o.pc_src));
            chk("halted",         32'(bus.halted),         32'(exp_o.halted));
            chk("error",          32'(bus.error),          32'(exp_error));
            chk("instr_count",    bus.instr_count,         32'(exp_count));
        end
    end

    // Called at posedge+1 of a cycle; returns at posedge+1 of the next one.
    task automatic drive_cycle(input int ph, input int op, input bit mr, input bit beq);
        bus.mem_ready = mr;
        bus.branch_eq = (ph == 2) ? beq : 1'($urandom_range(0, 1));
        // Outside DECODE present a different opcode to prove it is ignored.
        bus.opcode    = (ph == 1) ? 3'(op) : 3'((op + 1 + int'($urandom_range(0, 6))) % 8);
        exp_o         = model(ph, op, mr, bus.branch_eq);
        chk_en        = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input int op, input int fw, input int mw, input bit beq,
                             input bit timeout);
        int ph_q[$];
        bit mr_q[$];
        for (int k = 0; k < fw; k++) begin ph_q.push_back(0); mr_q.push_back(1'b0); end
        ph_q.push_back(0); mr_q.push_back(1'b1);
        ph_q.push_back(1); mr_q.push_back(1'($urandom_range(0, 1)));
        ph_q.push_back(2); mr_q.push_back(1'($urandom_range(0, 1)));
        if (op == 2 || op == 3) begin
            for (int k = 0; k < mw; k++) begin ph_q.push_back(3); mr_q.push_back(1'b0); end
            if (!timeout) begin ph_q.push_back(3); mr_q.push_back(1'b1); end
        end
        if (op <= 2) begin ph_q.push_back(4); mr_q.push_back(1'($urandom_range(0, 1))); end
        for (int i = 0; i < ph_q.size(); i++) begin
            drive_cycle(ph_q[i], op, mr_q[i], beq);
        end
        if (timeout) exp_error = 1'b1;
        else         exp_count++;
    endtask

    task automatic run_halted(input int n);
        for (int i = 0; i < n; i++) begin
            drive_cycle(5, int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0);
        end
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("rst_state",   32'(bus.state),   32'd0);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_count",   bus.instr_count,  32'd0);
        chk("rst_halted",  32'(bus.halted),  32'd0);
        chk("rst_error",   32'(bus.error),   32'd0);
        exp_count = 0;
        exp_error = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.opcode    = 3'd0;
        bus.mem_ready = 1'b0;
        bus.branch_eq = 1'b0;
        exp_o         = '0;
        @(posedge clk);
        #1;
        do_reset();

        run_instr(0, 0, 0, 1'b0, 1'b0);           // add: 4 cycles
        chk("add_count", bus.instr_count, 32'd1);
        run_instr(2, 3, 2, 1'b0, 1'b0);           // lw: 10 cycles with waits
        chk("lw_count", bus.instr_count, 32'd2);
        run_instr(4, 0, 0, 1'b1, 1'b0);           // beq taken
        run_instr(4, 0, 0, 1'b0, 1'b0);           // beq not taken
        run_instr(5, 0, 0, 1'b0, 1'b0);           // jalr
        run_instr(3, 0, 0, 1'b0, 1'b0);           // sw, no WB
        run_instr(1, 1, 0, 1'b0, 1'b0);           // nor with a fetch wait
        run_instr(7, 0, 0, 1'b0, 1'b0);           // noop
        run_instr(3, 0, 3, 1'b0, 1'b0);           // sw, 3 mem waits, no timeout
        chk("mid_count", bus.instr_count, 32'd9);
        chk("mid_state", 32'(bus.state), 32'd0);
        run_instr(6, 0, 0, 1'b0, 1'b0);           // halt
        run_halted(20);
        chk("halt_count", bus.instr_count, 32'd10);
        chk("halt_flag",  32'(bus.halted), 32'd1);

        do_reset();
        run_instr(0, 0, 0, 1'b0, 1'b0);
        run_instr(3, 0, 4, 1'b0, 1'b1);           // sw times out in MEM
        run_halted(3);
        chk("tmo_error", 32'(bus.error),  32'd1);
        chk("tmo_state", 32'(bus.state),  32'd5);
        chk("tmo_count", bus.instr_count, 32'd1);

        do_reset();
        chk_en        = 1'b0;
        bus.mem_ready = 1'b0;
        #1;
        chk("wait_mem_req", 32'(bus.mem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_mem_req", 32'(bus.mem_req), 32'd0);
        chk("async_state",   32'(bus.state),   32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_instr(7, 1, 0, 1'b0, 1'b0);
        chk("final_count", bus.instr_count, 32'd1);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/lc2k_control_fsm.md
# lc2k_control_fsm

Multicycle control sequencer for the LC2K datapath, successor to the single-cycle opcode-decode control table. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB states, drives datapath mux selects and write enables per state, handshakes with a variable-latency memory, and counts retired instructions. It sits between the instruction register/ALU flags and the register file, ALU, PC and memory port.

## Interface
Parameters:
- COUNT_WIDTH, 32, width of retired-instruction counter
- TIMEOUT_CYCLES, 0, max wait cycles for mem_ready per access; 0 disables timeout

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- opcode  in  3  instruction bits [24:22] from instruction register; sampled in DECODE
- mem_ready  in  1  memory completes current access this cycle
- branch_eq  in  1  ALU equality flag, valid in EXEC
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALTED=5
- mem_req  out  1  memory access request
- mem_write  out  1  1 = write, 0 = read; valid with mem_req
- ir_write  out  1  load instruction register
- reg_write  out  1  register file write enable
- write_reg_sel  out  1  1 = destReg, 0 = regB
- write_data_sel  out  2  0 = mem data, 1 = ALU result, 2 = PC+1
- alu_srcb  out  1  1 = regB value, 0 = sign-extended offset
- alu_op  out  2  0 = add, 1 = nor, 2 = equality compare
- pc_write  out  1  PC update enable
- pc_src  out  2  0 = PC+1, 1 = PC+1+offset, 2 = regA
- halted  out  1  sticky halt indication
- error  out  1  sticky memory-timeout indication
- instr_count  out  COUNT_WIDTH  retired instructions

## Operation
- Opcodes: add 0, nor 1, lw 2, sw 3, beq 4, jalr 5, halt 6, noop 7; all eight legal.
- FETCH: mem_req=1, mem_write=0; hold until mem_ready; on mem_ready ir_write=1 for that cycle, next DECODE.
- DECODE: latch opcode into internal register; all enables 0; next EXEC. Outputs in EXEC/MEM/WB decode from latched opcode only.
- EXEC:
  - add/nor: alu_srcb=1, alu_op=0/1; next WB.
  - lw/sw: alu_srcb=0, alu_op=0; next MEM.
  - beq: alu_srcb=1, alu_op=2, pc_write=1, pc_src=branch_eq?1:0; retire; next FETCH.
  - jalr: reg_write=1, write_reg_sel=0, write_data_sel=2, pc_write=1, pc_src=2; retire; next FETCH.
  - noop: pc_write=1, pc_src=0; retire; next FETCH.
  - halt: pc_write=1, pc_src=0; retire; next HALTED.
- MEM: mem_req=1, mem_write=(sw), alu_srcb=0, alu_op=0 held; hold until mem_ready. lw then WB; sw on mem_ready: pc_write=1, pc_src=0, retire, next FETCH.
- WB: reg_write=1, pc_write=1, pc_src=0; add/nor: write_reg_sel=1, write_data_sel=1, alu_srcb=1, alu_op held; lw: write_reg_sel=0, write_data_sel=0. Retire; next FETCH.
- HALTED: all enables and mem_req 0; halted=1; absorbing until reset.
- Retire: instr_count += 1 on the retiring cycle edge; wraps modulo 2^COUNT_WIDTH.
- Timeout (TIMEOUT_CYCLES>0): wait counter clears on entry to FETCH/MEM and on mem_ready; counts cycles with mem_req=1 and mem_ready=0; reaching TIMEOUT_CYCLES forces HALTED with error=1, no retire.
- Unlisted outputs are 0 in every state.

## Timing
- Reset (rst_n=0, async): state=FETCH, all enables/selects 0, halted=0, error=0, instr_count=0, wait counter=0, latched opcode=7. mem_req rises combinationally in FETCH once reset releases; first edge after release may complete fetch.
- Reset mid-access drops mem_req immediately; no partial retire.
- mem_req/mem_write stable while waiting; ir_write and MEM-exit pc_write are Mealy on mem_ready; pc_src in beq Mealy on branch_eq.
- Latency with mem_ready tied 1: add/nor 4 cycles, lw 5, sw 4, beq/jalr/noop 3, halt 3 then HALTED. Each mem wait cycle adds 1.
- opcode changes outside DECODE have no effect.

## Test plan
- add (opcode 0), mem_ready=1 -> states 0,1,2,4,0; WB cycle reg_write=1, write_reg_sel=1, write_data_sel=1, pc_write=1; instr_count 0→1.
- lw with mem_ready low 3 cycles in FETCH and 2 in MEM -> 10 cycles total, mem_write=0 throughout, WB write_data_sel=0, write_reg_sel=0.
- beq with branch_eq=1 then beq with branch_eq=0 -> EXEC pc_src=1 then 0, no reg_write, 3 cycles each.
- jalr -> EXEC reg_write=1, write_data_sel=2, pc_src=2; sw -> MEM mem_write=1, no WB state.
- halt -> HALTED after 3 cycles, halted=1, instr_count incremented; opcode/mem_ready toggling for 20 cycles changes nothing; rst_n low returns to FETCH with count 0.
- TIMEOUT_CYCLES=4, mem_ready held 0 in MEM for sw -> after 4 wait cycles HALTED, error=1, instr_count unchanged; async reset mid-wait clears mem_req same cycle.
